// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder built-in self-test controller.
package adder_bist_pkg;

  typedef enum logic [2:0] {IDLE, GAP, APPLY, CHECK, DONE} state_t;

  localparam int ERR_W = 16;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/adder_bist_seq.sv
// Vector index walker: j is the inner index, i the outer, pass_bit selects the second sweep.
module adder_bist_seq
  import adder_bist_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             pass_bit,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      i        <= '0;
      j        <= '0;
      pass_bit <= 1'b0;
    end else if (adv) begin
      if (j == IDX_LAST) begin
        j <= '0;
        if (i == IDX_LAST) begin
          i        <= '0;
          pass_bit <= 1'b1;
        end else begin
          i <= i + IDX_W'(1);
        end
      end else begin
        j <= j + IDX_W'(1);
      end
    end
  end

  assign last = pass_bit && (i == IDX_LAST) && (j == IDX_LAST);

endmodule

// File: rtl/adder_bist_ctrl.sv
// Two-pass windowed sweep of an external adder: drive operands, settle, compare
// {cout,sum} against a golden sum, count mismatches and keep the first failure.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYC    = 2,
  parameter int SETTLE_CYC = 8,
  parameter int N          = 16,
  parameter int A0_LO      = 0,
  parameter int B0_LO      = 16,
  parameter int A1_LO      = 80,
  parameter int B1_LO      = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] bin,
  output logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH:0]   fail_got
);

  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_MAX = (GAP_CYC > SETTLE_CYC) ? GAP_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             advance;
  logic             last_vec;
  logic             pass_bit;
  logic [IDX_W-1:0] idx_i;
  logic [IDX_W-1:0] idx_j;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   expect_sum;
  logic [WIDTH:0]   got;
  logic             mismatch;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign advance = (state == CHECK);

  adder_bist_seq #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .adv      (advance),
    .i        (idx_i),
    .j        (idx_j),
    .pass_bit (pass_bit),
    .last     (last_vec)
  );

  // Operand windows wrap modulo 2^WIDTH
  assign op_a = (pass_bit ? WIDTH'(A1_LO) : WIDTH'(A0_LO)) + WIDTH'(idx_i);
  assign op_b = (pass_bit ? WIDTH'(B1_LO) : WIDTH'(B0_LO)) + WIDTH'(idx_j);

  // Case inequality so unknown adder outputs are flagged rather than masked
  assign expect_sum = {1'b0, ain} + {1'b0, bin} + {{WIDTH{1'b0}}, cin};
  assign got        = {cout, sum};
  assign mismatch   = (got !== expect_sum);

  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ain        <= '0;
      bin        <= '0;
      cin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_got   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= GAP;
            cnt        <= '0;
            ain        <= '0;
            bin        <= '0;
            cin        <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
            fail_got   <= '0;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= APPLY;
            cnt   <= '0;
            ain   <= op_a;
            bin   <= op_b;
            cin   <= pass_bit;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        APPLY: begin
          if (cnt == SETTLE_LAST) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= ain;
              fail_b     <= bin;
              fail_cin   <= cin;
              fail_got   <= got;
            end
          end
          ain <= '0;
          bin <= '0;
          cin <= 1'b0;
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: a fault-injectable adder, a sweep-level reference model and a done-triggered scoreboard.
module tb_adder_bist_ctrl;

  localparam int WIDTH      = 8;
  localparam int GAP_CYC    = 2;
  localparam int SETTLE_CYC = 8;
  localparam int N          = 16;
  localparam int A0_LO      = 0;
  localparam int B0_LO      = 16;
  localparam int A1_LO      = 80;
  localparam int B1_LO      = 160;
  localparam int VEC_CYC    = GAP_CYC + SETTLE_CYC + 1;
  localparam int RUN_CYC    = 2 * N * N * VEC_CYC;
  localparam int MODW       = 1 << WIDTH;

  typedef struct {
    int errs;
    bit fv;
    int fa;
    int fb;
    int fc;
    int fgot;
    bit chk_got;
    int done_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic             fail_valid;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_cin;
  logic [WIDTH:0]   fail_got;

  logic [2:0]       fault_mode = 3'd0;
  logic [2:0]       fault_bit  = 3'd0;
  logic [WIDTH:0]   raw;

  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   run_start  = 0;
  bit   run_active = 1'b0;
  int   bad_ops    = 0;
  bit   done_q     = 1'b0;
  exp_t exp_q[$];

  adder_bist_ctrl #(
    .WIDTH(WIDTH), .GAP_CYC(GAP_CYC), .SETTLE_CYC(SETTLE_CYC), .N(N),
    .A0_LO(A0_LO), .B0_LO(B0_LO), .A1_LO(A1_LO), .B1_LO(B1_LO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ain        (ain),
    .bin        (bin),
    .cin        (cin),
    .sum        (sum),
    .cout       (cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_cin   (fail_cin),
    .fail_got   (fail_got)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test: 0 good, 1 cout stuck-0, 2 sum bit stuck-0, 3 unknown outputs, 4 sum bit stuck-1
  always_comb begin
    raw  = {1'b0, ain} + {1'b0, bin} + {{WIDTH{1'b0}}, cin};
    sum  = raw[WIDTH-1:0];
    cout = raw[WIDTH];
    case (fault_mode)
      3'd1: cout = 1'b0;
      3'd2: sum[fault_bit] = 1'b0;
      3'd3: begin
        sum  = 'x;
        cout = 1'bx;
      end
      3'd4: sum[fault_bit] = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] req_v);
    checks++;
    if (got_v !== req_v) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got_v, req_v, $time);
    end
  endtask

  // Adder result under a given fault, -1 meaning an unknown value
  function automatic int faulty_result(int a, int b, int c, int mode, int fb);
    int s;
    s = a + b + c;
    case (mode)
      1: s = s % MODW;
      2: s = s & ~(1 << fb);
      3: s = -1;
      4: s = s | (1 << fb);
      default: ;
    endcase
    return s;
  endfunction

  // Whole-run outcome: walk every vector in sweep order and tally
  function automatic exp_t model_run(int mode, int fb);
    exp_t e;
    int a, b, good, res;
    e = '{default: 0};
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a    = ((p == 1 ? A1_LO : A0_LO) + i) % MODW;
          b    = ((p == 1 ? B1_LO : B0_LO) + j) % MODW;
          good = a + b + p;
          res  = faulty_result(a, b, p, mode, fb);
          if (res != good) begin
            if (e.errs < 65535) e.errs++;
            if (!e.fv) begin
              e.fv   = 1'b1;
              e.fa   = a;
              e.fb   = b;
              e.fc   = p;
              e.fgot = res;
            end
          end
        end
    e.chk_got = (mode != 3);
    return e;
  endfunction

  // Monitor: operand schedule tracking while a run is active, scoreboard pop on done
  always @(negedge clk) begin
    int   off, v, p, vi, vj, ea, eb, ec;
    exp_t e;
    if (run_active) begin
      off = cyc - run_start;
      if (off >= 0 && off < RUN_CYC) begin
        v  = off / VEC_CYC;
        p  = v / (N * N);
        vi = (v % (N * N)) / N;
        vj = v % N;
        if ((off % VEC_CYC) < GAP_CYC) begin
          ea = 0; eb = 0; ec = 0;
        end else begin
          ea = ((p == 1 ? A1_LO : A0_LO) + vi) % MODW;
          eb = ((p == 1 ? B1_LO : B0_LO) + vj) % MODW;
          ec = p;
        end
        if (ain !== WIDTH'(ea) || bin !== WIDTH'(eb) || cin !== ec[0] ||
            busy !== 1'b1 || done !== 1'b0)
          bad_ops++;
      end
    end
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done rose with no run outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("err_count", err_count, e.errs);
        check("pass", pass, (e.errs == 0));
        check("busy_at_done", busy, 0);
        check("fail_valid", fail_valid, e.fv);
        if (e.fv) begin
          check("fail_a", fail_a, e.fa);
          check("fail_b", fail_b, e.fb);
          check("fail_cin", fail_cin, e.fc);
          if (e.chk_got) check("fail_got", fail_got, e.fgot);
        end
        check("operand_schedule_errors", bad_ops, 0);
      end
    end
    done_q = done;
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ain"}, ain, 0);
    check({tag, "_bin"}, bin, 0);
    check({tag, "_cin"}, cin, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_fail_valid"}, fail_valid, 0);
    check({tag, "_fail_got"}, {fail_a, fail_b, fail_cin, fail_got}, 0);
  endtask

  // One run: issue start, optionally spam start while busy, optionally abort with reset
  task automatic do_run(input int mode, input int fb, input bit spam, input int abort_at);
    exp_t e;
    int   k;
    bit   seen;
    @(negedge clk);
    fault_mode = 3'(mode);
    fault_bit  = 3'(fb);
    e          = model_run(mode, fb);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    bad_ops    = 0;
    run_start  = cyc;
    run_active = 1'b1;
    e.done_cyc = cyc + RUN_CYC;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      reset      = 1'b1;
      run_active = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state("abort");
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    exp_q.push_back(e);
    seen = 1'b0;
    for (k = 0; k < RUN_CYC + 40 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        start = spam && ($urandom_range(0, 63) == 0);
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, k);
      exp_q.delete();
    end
    repeat ($urandom_range(1, 12)) @(negedge clk);
  endtask

  initial begin
    int m;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_done_low", done, 0);

    do_run(0, 0, 1'b0, 0);          // clean adder
    do_run(1, 0, 1'b0, 0);          // cout stuck-0
    do_run(2, 0, 1'b0, 0);          // sum[0] stuck-0
    do_run(3, 0, 1'b0, 0);          // unknown outputs
    do_run(0, 0, 1'b1, 0);          // start spammed while busy
    do_run(4, $urandom_range(0, 7), 1'b0, 0);
    do_run(0, 0, 1'b0, 0);          // restart from DONE with a good adder
    do_run(0, 0, 1'b0, 3000);       // reset mid-run
    do_run(0, 0, 1'b0, 0);
    for (int r = 0; r < 3; r++) begin
      m = $urandom_range(0, 3);
      if (m == 3) m = 4;
      do_run(m, $urandom_range(0, 7), 1'($urandom_range(0, 1)), 0);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
